// File: rtl/tft_pkg.sv
// rtl/tft_pkg.sv - shared constants, FSM encoding and ROM word helper for the TFT link
package tft_pkg;

  typedef enum logic [1:0] {
    CMD   = 2'd0,
    DATA  = 2'd1,
    DELAY = 2'd2,
    END   = 2'd3
  } entry_kind_e;

  localparam logic [7:0] TFT_SWRESET = 8'h01;
  localparam logic [7:0] TFT_SLPOUT  = 8'h11;
  localparam logic [7:0] TFT_COLMOD  = 8'h3A;
  localparam logic [7:0] TFT_MADCTL  = 8'h36;
  localparam logic [7:0] TFT_DISPON  = 8'h29;
  localparam logic [7:0] TFT_CASET   = 8'h2A;
  localparam logic [7:0] TFT_PASET   = 8'h2B;
  localparam logic [7:0] TFT_RAMWR   = 8'h2C;

  typedef enum logic [2:0] {
    RST_LOW,
    RST_WAIT,
    INIT_FETCH,
    INIT_SHIFT,
    INIT_DELAY,
    IDLE,
    SHIFT
  } state_e;

  function automatic logic [9:0] rom_word(input entry_kind_e kind, input logic [7:0] value);
    return {kind, value};
  endfunction

endpackage

// File: rtl/tft_spi_link_if.sv
// rtl/tft_spi_link_if.sv - drawer byte handshake into the TFT SPI link
interface tft_spi_link_if;
  logic       tft_transmit;
  logic       tft_dc;
  logic [7:0] tft_data;
  logic       tft_busy;

  modport master (output tft_transmit, output tft_dc, output tft_data, input tft_busy);
  modport slave  (input tft_transmit, input tft_dc, input tft_data, output tft_busy);
endinterface

// File: rtl/tft_init_rom.sv
// rtl/tft_init_rom.sv - panel power-up command ROM, 18-bit colour configuration
module tft_init_rom
  import tft_pkg::*;
(
  input  logic [3:0] idx_i,
  output logic [9:0] entry_o
);

  always_comb begin
    entry_o = rom_word(END, 8'h00);
    case (idx_i)
      4'd0:    entry_o = rom_word(CMD,   TFT_SWRESET);
      4'd1:    entry_o = rom_word(DELAY, 8'd150);
      4'd2:    entry_o = rom_word(CMD,   TFT_SLPOUT);
      4'd3:    entry_o = rom_word(DELAY, 8'd150);
      4'd4:    entry_o = rom_word(CMD,   TFT_COLMOD);
      4'd5:    entry_o = rom_word(DATA,  8'h66);
      4'd6:    entry_o = rom_word(CMD,   TFT_MADCTL);
      4'd7:    entry_o = rom_word(DATA,  8'h48);
      4'd8:    entry_o = rom_word(CMD,   TFT_DISPON);
      4'd9:    entry_o = rom_word(DELAY, 8'd20);
      default: entry_o = rom_word(END,   8'h00);
    endcase
  end

endmodule

// File: rtl/tft_spi_link.sv
// rtl/tft_spi_link.sv - panel reset/init sequencer and mode-0 MSB-first SPI byte serialiser
module tft_spi_link
  import tft_pkg::*;
#(
  parameter int CLK_DIV    = 2,
  parameter int RST_CYCLES = 500000,
  parameter int DELAY_UNIT = 50000
) (
  input  logic          clk,
  input  logic          rst,
  tft_spi_link_if.slave drw,
  output logic          ready,
  output logic          tft_sck,
  output logic          tft_mosi,
  output logic          tft_cs_n,
  output logic          tft_dc_pin,
  output logic          tft_rst_n
);

  localparam int DLY_MAX = 255 * DELAY_UNIT;
  localparam int CNT_MAX = (RST_CYCLES > DLY_MAX) ? RST_CYCLES : DLY_MAX;
  localparam int CW      = $clog2(CNT_MAX + 1);
  localparam int DW      = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [CW-1:0] RST_LAST = CW'(RST_CYCLES - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);

  state_e          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [DW-1:0]   div_q, div_d;
  logic [3:0]      half_q, half_d;
  logic [6:0]      sh_q, sh_d;
  logic [3:0]      idx_q, idx_d;
  logic            busy_q, busy_d;
  logic            ready_q, ready_d;
  logic            sck_q, sck_d;
  logic            mosi_q, mosi_d;
  logic            cs_n_q, cs_n_d;
  logic            dc_pin_q, dc_pin_d;
  logic            rst_n_q, rst_n_d;

  logic [9:0]      rom_entry;
  logic [1:0]      rom_kind;
  logic [7:0]      rom_value;
  logic            start;
  logic [7:0]      start_byte;
  logic            start_dc;

  tft_init_rom u_rom (
    .idx_i   (idx_q),
    .entry_o (rom_entry)
  );

  assign rom_kind  = rom_entry[9:8];
  assign rom_value = rom_entry[7:0];

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    div_d      = div_q;
    half_d     = half_q;
    sh_d       = sh_q;
    idx_d      = idx_q;
    busy_d     = busy_q;
    ready_d    = ready_q;
    sck_d      = sck_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;
    dc_pin_d   = dc_pin_q;
    rst_n_d    = rst_n_q;
    start      = 1'b0;
    start_byte = 8'h00;
    start_dc   = 1'b0;

    case (state_q)
      RST_LOW: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          rst_n_d = 1'b1;
          state_d = RST_WAIT;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      RST_WAIT: begin
        if (cnt_q == RST_LAST) begin
          cnt_d   = '0;
          state_d = INIT_FETCH;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      INIT_FETCH: begin
        idx_d = idx_q + 4'd1;
        case (rom_kind)
          CMD, DATA: begin
            start      = 1'b1;
            start_byte = rom_value;
            start_dc   = rom_kind[0];
            state_d    = INIT_SHIFT;
          end
          DELAY: begin
            // A zero delay falls straight through to the next fetch.
            if (rom_value != 8'd0) begin
              cnt_d   = CW'(rom_value) * CW'(DELAY_UNIT) - CW'(1);
              state_d = INIT_DELAY;
            end
          end
          default: begin
            state_d = IDLE;
            ready_d = 1'b1;
            busy_d  = 1'b0;
          end
        endcase
      end
      INIT_DELAY: begin
        if (cnt_q == '0) begin
          state_d = INIT_FETCH;
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      IDLE: begin
        if (drw.tft_transmit && !busy_q) begin
          start      = 1'b1;
          start_byte = drw.tft_data;
          start_dc   = drw.tft_dc;
          busy_d     = 1'b1;
          state_d    = SHIFT;
        end
      end
      INIT_SHIFT, SHIFT: begin
        // cs_n already high inside a shift state marks the deselected tail cycle.
        if (cs_n_q) begin
          if (state_q == SHIFT) begin
            state_d = IDLE;
            busy_d  = 1'b0;
          end else begin
            state_d = INIT_FETCH;
          end
        end else if (div_q == DIV_LAST) begin
          div_d  = '0;
          half_d = half_q + 4'd1;
          if (!half_q[0]) begin
            sck_d = 1'b1;
          end else begin
            sck_d = 1'b0;
            if (half_q == 4'd15) begin
              cs_n_d = 1'b1;
            end else begin
              mosi_d = sh_q[6];
              sh_d   = {sh_q[5:0], 1'b0};
            end
          end
        end else begin
          div_d = div_q + DW'(1);
        end
      end
      default: state_d = RST_LOW;
    endcase

    if (start) begin
      cs_n_d   = 1'b0;
      sck_d    = 1'b0;
      dc_pin_d = start_dc;
      mosi_d   = start_byte[7];
      sh_d     = start_byte[6:0];
      div_d    = '0;
      half_d   = 4'd0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= RST_LOW;
      cnt_q    <= '0;
      div_q    <= '0;
      half_q   <= 4'd0;
      sh_q     <= 7'd0;
      idx_q    <= 4'd0;
      busy_q   <= 1'b1;
      ready_q  <= 1'b0;
      sck_q    <= 1'b0;
      mosi_q   <= 1'b0;
      cs_n_q   <= 1'b1;
      dc_pin_q <= 1'b0;
      rst_n_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      div_q    <= div_d;
      half_q   <= half_d;
      sh_q     <= sh_d;
      idx_q    <= idx_d;
      busy_q   <= busy_d;
      ready_q  <= ready_d;
      sck_q    <= sck_d;
      mosi_q   <= mosi_d;
      cs_n_q   <= cs_n_d;
      dc_pin_q <= dc_pin_d;
      rst_n_q  <= rst_n_d;
    end
  end

  assign drw.tft_busy = busy_q;
  assign ready        = ready_q;
  assign tft_sck      = sck_q;
  assign tft_mosi     = mosi_q;
  assign tft_cs_n     = cs_n_q;
  assign tft_dc_pin   = dc_pin_q;
  assign tft_rst_n    = rst_n_q;

endmodule

// File: tb/tb_tft_spi_link.sv
// tb/tb_tft_spi_link.sv - directed and random checks of the TFT SPI link against an SPI bus decoder
module tb_tft_spi_link;

  localparam int CLK_DIV    = 2;
  localparam int RST_CYCLES = 8;
  localparam int DELAY_UNIT = 4;
  localparam int BUSY_LEN   = 16 * CLK_DIV + 1;
  localparam int LOW_LEN    = 16 * CLK_DIV;
  localparam int PERIOD     = 16 * CLK_DIV + 2;

  typedef struct {
    logic [7:0] b;
    logic       dc;
    int         rises;
    int         fall_c;
    int         rise_c;
  } rec_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic ready, sck, mosi, cs_n, dc_pin, rst_n;

  tft_spi_link_if drw ();

  tft_spi_link #(
    .CLK_DIV    (CLK_DIV),
    .RST_CYCLES (RST_CYCLES),
    .DELAY_UNIT (DELAY_UNIT)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .drw        (drw),
    .ready      (ready),
    .tft_sck    (sck),
    .tft_mosi   (mosi),
    .tft_cs_n   (cs_n),
    .tft_dc_pin (dc_pin),
    .tft_rst_n  (rst_n)
  );

  always #5 clk = ~clk;

  // SPI bus decoder: one record per chip-select window, sampled on the falling clk edge.
  rec_t       mq[$];
  int         cyc = 0;
  logic       in_byte = 1'b0;
  logic       sck_prev = 1'b0;
  logic [7:0] sh = 8'h00;
  logic       dcb = 1'b0;
  int         rises = 0;
  int         fall_c = 0;

  always @(negedge clk) begin
    cyc      <= cyc + 1;
    sck_prev <= sck;
    if (rst) begin
      in_byte <= 1'b0;
    end else if (!in_byte) begin
      if (!cs_n) begin
        in_byte <= 1'b1;
        fall_c  <= cyc;
        sh      <= 8'h00;
        rises   <= 0;
        dcb     <= dc_pin;
      end
    end else if (cs_n) begin
      mq.push_back('{b: sh, dc: dcb, rises: rises, fall_c: fall_c, rise_c: cyc});
      in_byte <= 1'b0;
    end else if (sck && !sck_prev) begin
      sh    <= {sh[6:0], mosi};
      rises <= rises + 1;
    end
  end

  int total = 0;
  int bad   = 0;
  int rd    = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic check_range(input string tag, input int obs, input int lo, input int hi);
    total++;
    assert (obs >= lo && obs <= hi) else begin
      bad++;
      $error("FAIL %s: got %0d expected %0d..%0d", tag, obs, lo, hi);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic send(input logic [7:0] b, input logic dc);
    drw.tft_data     = b;
    drw.tft_dc       = dc;
    drw.tft_transmit = 1'b1;
    tick();
    drw.tft_transmit = 1'b0;
  endtask

  task automatic busy_len(output int n);
    n = 0;
    while (drw.tft_busy === 1'b1 && n < 200) begin
      n++;
      tick();
    end
  endtask

  task automatic check_byte(input string tag, input logic [7:0] b, input logic dc);
    check({tag, "_avail"}, 32'((mq.size() > rd) ? 1 : 0), 32'd1);
    if (mq.size() > rd) begin
      check({tag, "_byte"}, 32'(mq[rd].b), 32'(b));
      check({tag, "_dc"}, 32'(mq[rd].dc), 32'(dc));
      check({tag, "_rises"}, 32'(mq[rd].rises), 32'd8);
      check({tag, "_cslow"}, 32'(mq[rd].rise_c - mq[rd].fall_c), 32'(LOW_LEN));
      rd++;
    end
  endtask

  task automatic wait_ready(output int n, output logic pb);
    n  = 0;
    pb = 1'bx;
    while (ready !== 1'b1 && n < 6000) begin
      pb = drw.tft_busy;
      tick();
      n++;
    end
  endtask

  // Expected power-up traffic as {dc, byte} and the delay that follows each byte.
  logic [8:0] init_exp [7] = '{9'h001, 9'h011, 9'h03A, 9'h166, 9'h036, 9'h148, 9'h029};
  int         init_dly [7] = '{150 * DELAY_UNIT, 150 * DELAY_UNIT, 0, 0, 0, 0, 20 * DELAY_UNIT};

  initial begin
    int         n;
    int         base;
    logic       pb;
    logic [7:0] b;
    logic       dc;
    logic       prev_sck;
    int         r;

    drw.tft_transmit = 1'b0;
    drw.tft_dc       = 1'b0;
    drw.tft_data     = 8'h00;

    repeat (3) tick();
    check("reset_vals", 32'({drw.tft_busy, ready, sck, mosi, cs_n, dc_pin, rst_n}), 32'(7'b1000100));

    rst = 1'b0;
    n = 0;
    while (rst_n === 1'b0 && n < 100) begin
      n++;
      tick();
    end
    check("rst_low_len", 32'(n), 32'(RST_CYCLES));
    n = 0;
    while (cs_n === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    check_range("rst_wait_len", n, RST_CYCLES, RST_CYCLES + 2);
    check("rst_n_high", 32'(rst_n), 32'd1);

    send(8'h55, 1'b0);
    wait_ready(n, pb);
    check("init_ready", 32'(ready), 32'd1);
    check("init_busy_low", 32'(drw.tft_busy), 32'd0);
    check("init_busy_prev", 32'(pb), 32'd1);
    check("init_count", 32'(mq.size() - rd), 32'd7);
    base = rd;
    for (int i = 0; i < 7; i++) begin
      if (mq.size() > base + i && i > 0)
        check_range($sformatf("init_gap%0d", i), mq[base + i].fall_c - mq[base + i - 1].rise_c,
                    init_dly[i - 1] + 1, init_dly[i - 1] + 4);
      check_byte($sformatf("init%0d", i), init_exp[i][7:0], init_exp[i][8]);
    end
    if (mq.size() >= base + 7)
      check_range("init_end_gap", cyc - mq[base + 6].rise_c, init_dly[6] + 1, init_dly[6] + 4);
    rd = mq.size();

    send(8'h2A, 1'b0);
    busy_len(n);
    check("caset_busy", 32'(n), 32'(BUSY_LEN));
    check_byte("caset", 8'h2A, 1'b0);

    for (int k = 0; k < 6; k++) begin
      b  = 8'($urandom);
      dc = 1'($urandom);
      repeat ($urandom_range(0, 3)) tick();
      send(b, dc);
      busy_len(n);
      check($sformatf("rnd%0d_busy", k), 32'(n), 32'(BUSY_LEN));
      check_byte($sformatf("rnd%0d", k), b, dc);
    end

    base = rd;
    send(8'h00, 1'b1);
    busy_len(n);
    send(8'hFF, 1'b1);
    busy_len(n);
    check("b2b_busy", 32'(n), 32'(BUSY_LEN));
    if (mq.size() >= base + 2)
      check("b2b_period", 32'(mq[base + 1].fall_c - mq[base].fall_c), 32'(PERIOD));
    check_byte("b2b_first", 8'h00, 1'b1);
    check_byte("b2b_second", 8'hFF, 1'b1);

    b = 8'($urandom);
    send(b, 1'b1);
    repeat (10) tick();
    send(8'h55, 1'b0);
    busy_len(n);
    check_byte("midbyte", b, 1'b1);
    repeat (40) tick();
    check("midbyte_noextra", 32'(mq.size() - rd), 32'd0);
    check("midbyte_idle", 32'(drw.tft_busy), 32'd0);

    send(8'hC3, 1'b0);
    r        = 0;
    n        = 0;
    prev_sck = sck;
    while (r < 4 && n < 200) begin
      tick();
      n++;
      if (sck === 1'b1 && prev_sck === 1'b0) r++;
      prev_sck = sck;
    end
    check("rst_rises", 32'(r), 32'd4);
    #2 rst = 1'b1;
    #1;
    check("async_rst", 32'({cs_n, sck, rst_n, ready, drw.tft_busy}), 32'(5'b10001));
    repeat (3) tick();
    rd  = mq.size();
    rst = 1'b0;
    wait_ready(n, pb);
    check("reinit_ready", 32'(ready), 32'd1);
    check("reinit_count", 32'(mq.size() - rd), 32'd7);
    check_byte("reinit_first", 8'h01, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
